// File: rtl/fpga_robots_game_uart_rx.sv
// fpga_robots_game_uart_rx: 8N1 serial receiver, 8x oversampled on the baud8
// tick train, delivering bytes through a one-byte holding register with a
// valid/ready handshake and one-clk framing-error / overrun pulses.
`timescale 1ns/1ps
module fpga_robots_game_uart_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud8,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_ferr,
    output logic       rx_overrun,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StRecover
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [2:0]             tc_q, tc_d;
    logic [2:0]             bc_q, bc_d;
    logic [7:0]             shift_q, shift_d;
    logic                   frame_good;
    logic                   frame_bad;
    logic                   consume;

    assign rxs     = sync_q[SYNC_STAGES-1];
    assign consume = rx_valid & rx_ready;
    assign rx_busy = (state_q != StIdle);

    // Input synchronizer; resets to the idle-high level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    // Frame FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tc_q    <= '0;
            bc_q    <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            bc_q    <= bc_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic; everything except the holding register moves only on a tick.
    always_comb begin
        state_d    = state_q;
        tc_d       = tc_q;
        bc_d       = bc_q;
        shift_d    = shift_q;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if (baud8) begin
            unique case (state_q)
                StIdle: begin
                    if (!rxs) begin
                        state_d = StStart;
                        tc_d    = 3'd0;
                    end
                end
                StStart: begin
                    tc_d = tc_q + 3'd1;
                    if (tc_q == 3'd3) begin
                        // Line back high at mid start bit: treat as a glitch.
                        if (rxs) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StData;
                            tc_d    = 3'd0;
                            bc_d    = 3'd0;
                        end
                    end
                end
                StData: begin
                    tc_d = tc_q + 3'd1;
                    if (tc_q == 3'd7) begin
                        shift_d = {rxs, shift_q[7:1]};
                        bc_d    = bc_q + 3'd1;
                        if (bc_q == 3'd7) begin
                            state_d = StStop;
                            tc_d    = 3'd0;
                        end
                    end
                end
                StStop: begin
                    tc_d = tc_q + 3'd1;
                    if (tc_q == 3'd7) begin
                        if (rxs) begin
                            frame_good = 1'b1;
                            state_d    = StIdle;
                        end else begin
                            frame_bad = 1'b1;
                            state_d   = StRecover;
                        end
                    end
                end
                StRecover: begin
                    // Wait for the line to go idle so a break cannot re-trigger a start.
                    if (rxs) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Holding register, handshake and registered error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_ferr    <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_ferr    <= frame_bad;
            rx_overrun <= frame_good & rx_valid & ~rx_ready;
            if (frame_good && (!rx_valid || consume)) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (consume) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
